// File: rtl/grad_dir_cordic.sv
// Gradient orientation binning: vectoring-mode CORDIC that turns a signed (dx, dy) pair into
// an orientation bin, an unnormalised magnitude (x K) and a zero-gradient flag.
module grad_dir_cordic #(
   parameter int unsigned DW    = 8,
   parameter int unsigned BIN_W = 5,
   parameter int unsigned ITER  = 12,
   parameter int unsigned ROUND = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DW-1:0]     in_dx,
   input  logic [DW-1:0]     in_dy,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [BIN_W-1:0]  out_bin,
   output logic [DW:0]       out_mag,
   output logic              out_zero
);

   localparam int unsigned XW     = DW + 2;
   localparam logic [4:0]  ITER_L = 5'(ITER);
   localparam logic [15:0] HALF   = (ROUND != 0) ? (16'(1) << (15 - BIN_W)) : 16'(0);

   typedef enum logic [1:0] {st_idle, st_rot, st_bin, st_out} state_t;

   state_t                state;
   logic signed [XW-1:0]  x, y;
   logic [15:0]           z;
   logic [4:0]            i;
   logic                  zin;

   logic signed [XW-1:0]  dx_ext, dy_ext, xs, ys;
   logic [15:0]           zr;

   function automatic logic [15:0] atan_lut(input logic [3:0] k);
      case (k)
         4'd0:    atan_lut = 16'd8192;
         4'd1:    atan_lut = 16'd4836;
         4'd2:    atan_lut = 16'd2555;
         4'd3:    atan_lut = 16'd1297;
         4'd4:    atan_lut = 16'd651;
         4'd5:    atan_lut = 16'd326;
         4'd6:    atan_lut = 16'd163;
         4'd7:    atan_lut = 16'd81;
         4'd8:    atan_lut = 16'd41;
         4'd9:    atan_lut = 16'd20;
         4'd10:   atan_lut = 16'd10;
         4'd11:   atan_lut = 16'd5;
         4'd12:   atan_lut = 16'd3;
         4'd13:   atan_lut = 16'd1;
         4'd14:   atan_lut = 16'd1;
         default: atan_lut = 16'd0;
      endcase
   endfunction

   always_comb begin
      dx_ext = {{2{in_dx[DW-1]}}, in_dx};
      dy_ext = {{2{in_dy[DW-1]}}, in_dy};
      xs     = x >>> i[3:0];
      ys     = y >>> i[3:0];
      zr     = z + HALF;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= st_idle;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_bin   <= '0;
         out_mag   <= '0;
         out_zero  <= 1'b0;
         x         <= '0;
         y         <= '0;
         z         <= '0;
         i         <= '0;
         zin       <= 1'b0;
      end else begin
         case (state)
            st_idle: begin
               if (in_valid && in_ready) begin
                  in_ready <= 1'b0;
                  // Pre-rotate the left half-plane by 180 deg so the CORDIC converges
                  if (in_dx[DW-1]) begin
                     x <= -dx_ext;
                     y <= -dy_ext;
                     z <= 16'h8000;
                  end else begin
                     x <= dx_ext;
                     y <= dy_ext;
                     z <= 16'h0000;
                  end
                  zin   <= (in_dx == '0) && (in_dy == '0);
                  i     <= '0;
                  state <= st_rot;
               end else begin
                  in_ready <= 1'b1;
               end
            end
            st_rot: begin
               // i == ITER is a settle cycle that aligns result latency to ITER+2
               if (i < ITER_L) begin
                  if (!y[XW-1]) begin
                     x <= x + ys;
                     y <= y - xs;
                     z <= z + atan_lut(i[3:0]);
                  end else begin
                     x <= x - ys;
                     y <= y + xs;
                     z <= z - atan_lut(i[3:0]);
                  end
                  i <= i + 5'd1;
               end else begin
                  state <= st_bin;
               end
            end
            st_bin: begin
               out_valid <= 1'b1;
               out_zero  <= zin;
               out_bin   <= zin ? '0 : zr[15 -: BIN_W];
               out_mag   <= zin ? '0 : x[DW:0];
               state     <= st_out;
            end
            st_out: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= st_idle;
               end
            end
            default: state <= st_idle;
         endcase
      end
   end

endmodule

// File: tb/tb_grad_dir_cordic.sv
// Scoreboard bench for grad_dir_cordic: a rounding instance and a truncating instance share stimulus.
module tb_grad_dir_cordic;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b1;
   logic [7:0] in_dx = '0;
   logic [7:0] in_dy = '0;
   logic       in_ready, out_valid, out_zero;
   logic [4:0] out_bin;
   logic [8:0] out_mag;
   logic       t_in_ready, t_out_valid, t_out_zero;
   logic [4:0] t_out_bin;
   logic [8:0] t_out_mag;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      int bin;
      int tbin;   // truncating-instance bin, -1 where the angle sits within CORDIC error of an edge
      int zero;
      int mag;
      int tol;
      int hs;
   } exp_t;
   exp_t q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   grad_dir_cordic #(.DW(8), .BIN_W(5), .ITER(12), .ROUND(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_dx(in_dx),
      .in_dy(in_dy), .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin),
      .out_mag(out_mag), .out_zero(out_zero)
   );

   grad_dir_cordic #(.DW(8), .BIN_W(5), .ITER(12), .ROUND(0)) dut_trunc (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(t_in_ready), .in_dx(in_dx),
      .in_dy(in_dy), .out_valid(t_out_valid), .out_ready(out_ready), .out_bin(t_out_bin),
      .out_mag(t_out_mag), .out_zero(t_out_zero)
   );

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_range(input string name, input int act, input int exp, input int tol);
      total++;
      if (act < exp - tol || act > exp + tol) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d +/- %0d (cycle %0d)", name, act, exp, tol, cyc);
      end
   endtask

   // Monitor samples a little after the falling edge so driver updates have settled
   bit prev_v = 1'b0;
   always begin
      exp_t e;
      @(negedge clk);
      #2;
      if (!rst) begin
         if (out_valid && !prev_v) begin
            if (q.size() == 0) chk("spurious_out_valid", 1, 0);
            else               chk("latency", cyc - q[0].hs, 14);
         end
         if (out_valid && out_ready && q.size() > 0) begin
            e = q.pop_front();
            chk("bin", int'(out_bin), e.bin);
            chk("zero", int'(out_zero), e.zero);
            chk_range("mag", int'(out_mag), e.mag, e.tol);
            if (e.tbin >= 0) begin
               chk("trunc_valid", int'(t_out_valid), 1);
               chk("trunc_bin", int'(t_out_bin), e.tbin);
            end
         end
      end
      prev_v = out_valid;
   end

   task automatic send(input int dx, input int dy, input int bin, input int tbin,
                       input int zero, input int mag, input int tol);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         chk("in_ready_timeout", 0, 1);
         return;
      end
      in_dx    = 8'(dx);
      in_dy    = 8'(dy);
      in_valid = 1'b1;
      q.push_back('{bin, tbin, zero, mag, tol, cyc + 1});
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() > 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain_left", q.size(), 0);
   endtask

   initial begin
      logic [4:0] hb;
      logic [8:0] hm;
      int         n;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_bin", int'(out_bin), 0);
      chk("rst_out_mag", int'(out_mag), 0);
      chk("rst_out_zero", int'(out_zero), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("in_ready_after_rst", int'(in_ready), 1);

      // Axes, diagonal/extreme, wrap, zero, generic angle
      send(100, 0, 0, -1, 0, 165, 6);
      send(0, 100, 8, -1, 0, 165, 6);
      send(-100, 0, 16, -1, 0, 165, 6);
      send(0, -100, 24, -1, 0, 165, 6);
      send(-128, -128, 20, -1, 0, 298, 4);
      send(127, -128, 28, -1, 0, 297, 6);
      send(100, -5, 0, 31, 0, 165, 6);
      send(0, 0, 0, 0, 1, 0, 0);
      send(0, 50, 8, -1, 0, 82, 6);
      send(100, 60, 3, 2, 0, 192, 6);
      drain();

      // Backpressure: result must hold, in_ready low, pulsed input ignored
      out_ready = 1'b0;
      send(0, 100, 8, -1, 0, 165, 6);
      n = 0;
      while (!out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("bp_out_valid", int'(out_valid), 1);
      hb = out_bin;
      hm = out_mag;
      for (int k = 0; k < 20; k++) begin
         if (k == 5) begin
            in_dx    = 8'(-50);
            in_dy    = 8'(-50);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         chk("bp_hold_valid", int'(out_valid), 1);
         chk("bp_hold_bin", int'(out_bin), int'(hb));
         chk("bp_hold_mag", int'(out_mag), int'(hm));
         chk("bp_in_ready", int'(in_ready), 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_valid", int'(out_valid), 0);
      chk("bp_release_in_ready", int'(in_ready), 1);
      drain();

      // Reset during the fifth rotation cycle discards the pending result
      send(0, 100, 8, -1, 0, 165, 6);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      q.delete();
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_in_ready", int'(in_ready), 0);
      chk("midrst_out_bin", int'(out_bin), 0);
      chk("midrst_out_mag", int'(out_mag), 0);
      chk("midrst_out_zero", int'(out_zero), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_release_in_ready", int'(in_ready), 1);
      send(0, 100, 8, -1, 0, 165, 6);
      drain();

      repeat (3) @(negedge clk);
      chk("no_extra_output", int'(out_valid), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

endmodule
